prefix_addsub_pipe: RTL and testbench
=====================================

// Module: prefix_addsub_pipe
// PURPOSE
//  Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor with valid/ready flow control.
//  Generalises the fixed 32-bit pipelined prefix adder in three ways:
//  - any power-of-two width;
//  - selectable number of prefix levels per pipeline stage;
//  - add/sub mode, plus carry, overflow and zero flags.
//  It sits in the execute stage as the ALU's adder datapath.
// PARAMETERS
//  WIDTH        32  operand width; power of two, 4..64
//  LVL_PER_STG  1   prefix levels per register stage, 1..log2(WIDTH)
// PORTS
//  clock      in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  valid_in   in   1      operand beat valid
//  ready_in   out  1      block can accept a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: A+B+cin ; 1: A-B-cin
//  flush      in   1      synchronous kill of all in-flight beats
//  valid_out  out  1      result valid
//  ready_out  in   1      downstream accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry-out (sub: 1 = no borrow)
//  ovf        out  1      signed two's-complement overflow
//  zero       out  1      sum == 0
// BEHAVIOUR
//  Reset:
//  - reset_n=0 asynchronously clears every pipeline register.
//  - valid_out, sum, cout, ovf and zero are all 0 while in reset.
//  Depth and latency:
//  - LEVELS = log2(WIDTH); NSTG = ceil(LEVELS/LVL_PER_STG); LAT = NSTG+1.
//  - Stage 1 forms b_eff = sub ? ~b : b, c0 = cin ^ sub, g = a&b_eff, p = a^b_eff, then LVL_PER_STG prefix levels, then registers.
//  - Stages 2..NSTG each do LVL_PER_STG levels (the last stage may do fewer), then register.
//  - The final stage registers sum = p ^ {carries[WIDTH-1:0]}, cout = carry[WIDTH], and the flags.
//  - p and c0 travel alongside through every stage.
//  - An accepted beat appears on valid_out exactly LAT clocks after acceptance, provided there is no stall.
//  - Example: WIDTH=32, LVL_PER_STG=1 gives LAT=6.
//  Flags:
//  - ovf = carry[WIDTH] ^ carry[WIDTH-1].
//  - zero = ~|sum.
//  Flow control (global stall, no bubble collapse):
//  - adv = ~valid_out | ready_out; ready_in = adv (combinational).
//  - adv=1: every stage loads from its predecessor; the stage-1 valid loads valid_in.
//  - adv=0: every register holds; sum and flags stay stable while valid_out=1 and ready_out=0.
//  - A beat is accepted when valid_in & ready_in. valid_in while ready_in=0 is ignored; the source must hold it.
//  Flush:
//  - flush=1 clears all stage valid bits on the next edge, regardless of adv.
//  - A beat offered in the same cycle as flush is dropped.
//  - Data registers may keep stale values; only the valids are defined.
//  Boundaries:
//  - sum wraps modulo 2^WIDTH.
//  - In subtraction, a-b with a<b gives cout=0.
//  - reset_n deasserted mid-stream: all in-flight beats are lost; output stays invalid until new beats traverse LAT stages.
//  - flush together with a stall: flush wins.
// TESTING
//  - 32b, L=1, add a=FFFFFFFF b=1 cin=0 -> cycle 6: sum=0 cout=1 zero=1 ovf=0.
//  - sub a=5 b=7 cin=0 -> sum=FFFFFFFE cout=0 ovf=0; sub a=80000000 b=1 -> sum=7FFFFFFF ovf=1.
//  - add a=7FFFFFFF b=0 cin=1 -> sum=80000000 ovf=1 cout=0; a=0 b=0 cin=0 -> zero=1.
//  - 100 back-to-back beats with ready_out toggled randomly -> results in order, none lost or duplicated, values stable during stall.
//  - reset_n low for 1 cycle with 4 beats in flight -> valid_out=0 until a new beat completes; flush the same way.
//  - WIDTH in {8,16,64} x LVL_PER_STG in {1,2,max}, 10k random beats vs behavioural model -> zero mismatches, LAT as formula.

Source files
------------

// File: rtl/prefix_addsub_pipe_if.sv
// Operand/result handshake bundle for prefix_addsub_pipe.
// WIDTH must match the WIDTH of the attached prefix_addsub_pipe.
interface prefix_addsub_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_in;
    logic             ready_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             flush;
    logic             valid_out;
    logic             ready_out;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output valid_in, a, b, cin, sub, flush, ready_out,
        input  ready_in, valid_out, sum, cout, ovf, zero
    );

    modport slave (
        input  valid_in, a, b, cin, sub, flush, ready_out,
        output ready_in, valid_out, sum, cout, ovf, zero
    );
endinterface

// File: rtl/prefix_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control and a global stall.
// Latency is ceil(log2(WIDTH)/LVL_PER_STG) prefix stages plus one output stage.
module prefix_addsub_pipe #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned LVL_PER_STG = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    prefix_addsub_pipe_if.slave  bus
);
    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned NSTG   = (LEVELS + LVL_PER_STG - 1) / LVL_PER_STG;

    logic adv;
    assign adv         = ~bus.valid_out | bus.ready_out;
    assign bus.ready_in = adv;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g0;
    logic [WIDTH-1:0] p0;
    logic             c0;

    always_comb begin
        b_eff = bus.sub ? ~bus.b : bus.b;
        g0    = bus.a & b_eff;
        p0    = bus.a ^ b_eff;
        c0    = bus.cin ^ bus.sub;
    end

    // Each stage carries group generate/propagate (gq/ppq) plus the raw
    // bit propagate (pq) and carry-in needed by the output stage.
    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        logic [WIDTH-1:0] g_in, pp_in, p_in;
        logic             v_in, c0_in;
        logic [WIDTH-1:0] g_nx, pp_nx, gt, pt;
        logic [WIDTH-1:0] gq, ppq, pq;
        logic             vq, c0q;

        if (s == 0) begin : g_first
            assign g_in  = g0;
            assign pp_in = p0;
            assign p_in  = p0;
            assign c0_in = c0;
            assign v_in  = bus.valid_in;
        end else begin : g_rest
            assign g_in  = g_stg[s-1].gq;
            assign pp_in = g_stg[s-1].ppq;
            assign p_in  = g_stg[s-1].pq;
            assign c0_in = g_stg[s-1].c0q;
            assign v_in  = g_stg[s-1].vq;
        end

        always_comb begin
            g_nx  = g_in;
            pp_nx = pp_in;
            gt    = '0;
            pt    = '0;
            for (int unsigned l = s * LVL_PER_STG;
                 l < LEVELS && l < (s + 1) * LVL_PER_STG; l++) begin
                gt = g_nx;
                pt = pp_nx;
                for (int unsigned i = (1 << l); i < WIDTH; i++) begin
                    g_nx[i]  = gt[i] | (pt[i] & gt[i - (1 << l)]);
                    pp_nx[i] = pt[i] & pt[i - (1 << l)];
                end
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                vq  <= 1'b0;
                gq  <= '0;
                ppq <= '0;
                pq  <= '0;
                c0q <= 1'b0;
            end else begin
                if (bus.flush) begin
                    vq <= 1'b0;
                end else if (adv) begin
                    vq <= v_in;
                end
                if (adv) begin
                    gq  <= g_nx;
                    ppq <= pp_nx;
                    pq  <= p_in;
                    c0q <= c0_in;
                end
            end
        end
    end

    // After the last level gq[i]/ppq[i] span bits [i:0], so each carry is
    // resolved against c0 in one step.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_nx;
    logic             vf;

    always_comb begin
        carry  = {g_stg[NSTG-1].gq | (g_stg[NSTG-1].ppq & {WIDTH{g_stg[NSTG-1].c0q}}),
                  g_stg[NSTG-1].c0q};
        sum_nx = g_stg[NSTG-1].pq ^ carry[WIDTH-1:0];
        vf     = g_stg[NSTG-1].vq;
    end

    logic             vout_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vout_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (bus.flush) begin
                vout_q <= 1'b0;
            end else if (adv) begin
                vout_q <= vf;
            end
            if (adv) begin
                sum_q  <= sum_nx;
                cout_q <= carry[WIDTH];
                ovf_q  <= carry[WIDTH] ^ carry[WIDTH-1];
                zero_q <= ~|sum_nx;
            end
        end
    end

    assign bus.valid_out = vout_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Scoreboard bench: a 32-bit/1-level pipe with directed and stall/flush/reset
// scenarios, plus an 8-bit single-stage pipe under random traffic.
module tb_prefix_addsub_pipe;
    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    int unsigned nchk = 0;
    int unsigned nerr = 0;
    bit          rnd_rdy = 1'b0;
    exp_t        q32[$];
    exp_t        q8[$];

    always #5 clock = ~clock;

    prefix_addsub_pipe_if #(.WIDTH(32)) bus ();
    prefix_addsub_pipe_if #(.WIDTH(8))  bus8 ();

    prefix_addsub_pipe #(.WIDTH(32), .LVL_PER_STG(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    prefix_addsub_pipe #(.WIDTH(8), .LVL_PER_STG(3)) dut8 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus8)
    );

    function automatic exp_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint full, half, ua, ub, sa, sb, ci, t, st;
        full = longint'(1) << w;
        half = full >> 1;
        ua   = longint'(a) & (full - 1);
        ub   = longint'(b) & (full - 1);
        ci   = longint'(cin);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        if (sub) begin
            t    = ua - ub - ci;
            st   = sa - sb - ci;
            e.co = (t >= 0);
        end else begin
            t    = ua + ub + ci;
            st   = sa + sb + ci;
            e.co = (t >= full);
        end
        e.s  = 32'(t & (full - 1));
        e.ov = (st < -half) || (st >= half);
        e.z  = (e.s == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (bus.valid_out) begin
            nchk++;
            assert (q32.size() != 0) else begin
                nerr++;
                $error("FAIL sb32_extra got=%h exp=none", bus.sum);
            end
            if (q32.size() != 0) begin
                e = q32[0];
                nchk++;
                assert ({bus.sum, bus.cout, bus.ovf, bus.zero} === {e.s, e.co, e.ov, e.z}) else begin
                    nerr++;
                    $error("FAIL sb32 got=%h/%b%b%b exp=%h/%b%b%b", bus.sum, bus.cout, bus.ovf,
                           bus.zero, e.s, e.co, e.ov, e.z);
                end
                if (bus.ready_out) void'(q32.pop_front());
            end
        end
        if (!reset_n || bus.flush) q32.delete();
        else if (bus.valid_in && bus.ready_in)
            q32.push_back(model(32, bus.a, bus.b, bus.cin, bus.sub));
    end

    always @(negedge clock) begin
        exp_t e;
        if (bus8.valid_out) begin
            nchk++;
            assert (q8.size() != 0) else begin
                nerr++;
                $error("FAIL sb8_extra got=%h exp=none", bus8.sum);
            end
            if (q8.size() != 0) begin
                e = q8[0];
                nchk++;
                assert ({bus8.sum, bus8.cout, bus8.ovf, bus8.zero} === {e.s[7:0], e.co, e.ov, e.z}) else begin
                    nerr++;
                    $error("FAIL sb8 got=%h/%b%b%b exp=%h/%b%b%b", bus8.sum, bus8.cout, bus8.ovf,
                           bus8.zero, e.s[7:0], e.co, e.ov, e.z);
                end
                if (bus8.ready_out) void'(q8.pop_front());
            end
        end
        if (!reset_n || bus8.flush) q8.delete();
        else if (bus8.valid_in && bus8.ready_in)
            q8.push_back(model(8, {24'd0, bus8.a}, {24'd0, bus8.b}, bus8.cin, bus8.sub));
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (rnd_rdy) begin
            bus.ready_out  = 1'($urandom_range(0, 1));
            bus8.ready_out = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        bit done = 1'b0;
        bus.valid_in = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            done = bus.ready_in;
            step();
        end
        bus.valid_in = 1'b0;
        chk("accept32", 64'(done), 64'd1);
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        bit done = 1'b0;
        bus8.valid_in = 1'b1;
        bus8.a        = a;
        bus8.b        = b;
        bus8.cin      = cin;
        bus8.sub      = sub;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            done = bus8.ready_in;
            step();
        end
        bus8.valid_in = 1'b0;
        chk("accept8", 64'(done), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (q32.size() == 0 && q8.size() == 0 && !bus.valid_out && !bus8.valid_out) break;
            step();
        end
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("drain8", 64'(q8.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset_n        = 1'b0;
        bus.valid_in   = 1'b0;  bus.a  = '0;  bus.b  = '0;  bus.cin  = 1'b0;  bus.sub  = 1'b0;
        bus.flush      = 1'b0;  bus.ready_out  = 1'b1;
        bus8.valid_in  = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;  bus8.sub = 1'b0;
        bus8.flush     = 1'b0;  bus8.ready_out = 1'b1;
        step();
        chk("rst_vout", 64'(bus.valid_out), 64'd0);
        chk("rst_flags", {bus.sum, bus.cout, bus.ovf, bus.zero}, 64'd0);
        step();
        reset_n = 1'b1;
        step();

        // First beat: latency and the all-ones + 1 wrap
        bus.a = 32'hFFFF_FFFF; bus.b = 32'h1; bus.cin = 1'b0; bus.sub = 1'b0; bus.valid_in = 1'b1;
        @(posedge clock);
        #1;
        bus.valid_in = 1'b0;
        cnt = 1;
        while (!bus.valid_out && cnt < 20) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        chk("lat32", 64'(cnt), 64'd6);
        chk("wrap32", {bus.sum, bus.cout, bus.zero, bus.ovf}, {32'h0, 1'b1, 1'b1, 1'b0});
        drain();

        send32(32'h5, 32'h7, 1'b0, 1'b1);
        send32(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        send32(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
        send32(32'h0, 32'h0, 1'b0, 1'b0);
        send32(32'h0, 32'h0, 1'b1, 1'b1);
        send32(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        drain();

        // Back-to-back traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) step();
        end
        rnd_rdy = 1'b0;
        bus.ready_out = 1'b1;
        bus8.ready_out = 1'b1;
        drain();

        // Reset pulse with four beats in flight
        for (int i = 0; i < 4; i++) send32($urandom, $urandom, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_vout", 64'(bus.valid_out), 64'd0);
        chk("midrst_sum", 64'(bus.sum), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("midrst_idle", 64'(bus.valid_out), 64'd0);
        end
        send32(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        drain();

        // Flush while the pipe is stalled, with a beat offered in the same cycle
        bus.ready_out = 1'b0;
        for (int i = 0; i < 4; i++) send32($urandom, $urandom, 1'b1, 1'b1);
        repeat (4) step();
        chk("stall_vout", 64'(bus.valid_out), 64'd1);
        chk("stall_rdyin", 64'(bus.ready_in), 64'd0);
        bus.flush = 1'b1;
        bus.valid_in = 1'b1;
        bus.a = 32'hDEAD_BEEF;
        step();
        bus.flush = 1'b0;
        bus.valid_in = 1'b0;
        chk("flush_vout", 64'(bus.valid_out), 64'd0);
        bus.ready_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("flush_idle", 64'(bus.valid_out), 64'd0);
        end
        send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drain();

        // 8-bit single-stage pipe: latency then random traffic
        bus8.a = 8'h7F; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.valid_in = 1'b1;
        @(posedge clock);
        #1;
        bus8.valid_in = 1'b0;
        cnt = 1;
        while (!bus8.valid_out && cnt < 20) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        chk("lat8", 64'(cnt), 64'd2);
        chk("ovf8", {bus8.sum, bus8.cout, bus8.ovf, bus8.zero}, {8'h80, 1'b0, 1'b1, 1'b0});
        drain();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++)
            send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rnd_rdy = 1'b0;
        bus.ready_out = 1'b1;
        bus8.ready_out = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
